// File: rtl/scan_chain_pkg.sv
// Shared encodings for the scan chain sequencer: command opcodes and FSM states.
package scan_chain_pkg;

  typedef enum logic [1:0] {
    OP_SHIFT   = 2'b00,
    OP_CAPTURE = 2'b01,
    OP_TEST    = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAP       = 3'd2,
    SHIFT_OUT = 3'd3,
    RESP      = 3'd4
  } state_e;

endpackage

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: loads a pattern serially, optionally captures, unloads
// the chain into a parallel response. All outputs are registered.
module scan_chain_ctrl
  import scan_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 32
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 scan_se,
  output logic                 scan_si,
  input  logic                 scan_so,
  output logic                 scan_cke
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e               state, state_n;
  op_e                  op, op_n;
  logic [CNT_W-1:0]     count, count_n;
  logic [CHAIN_LEN-1:0] shreg, shreg_n;
  logic                 err_n;
  logic                 shifting_n;
  logic                 accept;

  assign accept = (state == IDLE) && cmd_valid && cmd_ready;

  // NOTE: every variable is given a default before the case so no path leaves
  // one unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_n = state;
    op_n    = op;
    count_n = count;
    shreg_n = shreg;
    err_n   = rsp_err;

    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_n = cmd_data;
          op_n    = op_e'(cmd_op);
          unique case (op_e'(cmd_op))
            OP_SHIFT, OP_TEST: begin
              state_n = SHIFT_IN;
              count_n = CNT_LOAD;
            end
            OP_CAPTURE: state_n = CAP;
            OP_RSVD: begin
              state_n = RESP;
              err_n   = 1'b1;
            end
          endcase
        end
      end

      SHIFT_IN: begin
        // The chain shifts on this same edge, so scan_so is the bit leaving it.
        shreg_n = {scan_so, shreg[CHAIN_LEN-1:1]};
        count_n = count - CNT_ONE;
        if (count == CNT_ONE) begin
          state_n = (op == OP_TEST) ? CAP : RESP;
        end
      end

      CAP: begin
        // Cleared so the unload shifts zeros into the chain and a bare
        // capture reports an all-zero response.
        shreg_n = '0;
        if (op == OP_TEST) begin
          state_n = SHIFT_OUT;
          count_n = CNT_LOAD;
        end else begin
          state_n = RESP;
        end
      end

      SHIFT_OUT: begin
        shreg_n = {scan_so, shreg[CHAIN_LEN-1:1]};
        count_n = count - CNT_ONE;
        if (count == CNT_ONE) begin
          state_n = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_n = IDLE;
          err_n   = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign shifting_n = (state_n == SHIFT_IN) || (state_n == SHIFT_OUT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching real flops regardless of statement order.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state     <= IDLE;
      op        <= OP_SHIFT;
      count     <= '0;
      shreg     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      scan_se   <= 1'b0;
      scan_si   <= 1'b0;
      scan_cke  <= 1'b0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      count     <= count_n;
      shreg     <= shreg_n;
      cmd_ready <= (state_n == IDLE);
      rsp_valid <= (state_n == RESP);
      rsp_err   <= err_n;
      rsp_data  <= (state_n == RESP) ? shreg_n : '0;
      // Pins are decoded from the next state so they line up with that state.
      scan_se   <= shifting_n;
      scan_si   <= shifting_n ? shreg_n[0] : 1'b0;
      scan_cke  <= shifting_n || (state_n == CAP);
    end
  end

endmodule
